// File: rtl/complete_buffer.sv
// ---------------------------------------------------------------------------
// complete_buffer
//
// Completion stage that sits right after execute. Up to N_IN finished results
// per cycle are compacted, in ascending lane order, into an in-order circular
// FIFO. One entry retires per cycle onto the CDB, the PRF write port and the
// ROB complete port.
//
// Optional feature: define COMPLETE_BYPASS_EN to let the lowest valid lane
// skip the FIFO when it is empty. That lane is then broadcast in the same
// cycle it arrives.
//
// Ports
//   clock            : rising-edge clock
//   reset            : asynchronous, active-low reset
//   ex_valid         : per-lane result valid
//   ex_tag           : per-lane destination preg, lane i at [i*PREG_W +: PREG_W]
//   ex_rob_idx       : per-lane ROB index, lane i at [i*ROB_W +: ROB_W]
//   ex_result        : per-lane result data, lane i at [i*XLEN +: XLEN]
//   squash           : synchronous flush; same-cycle inputs are discarded
//   ex_stall         : back-pressure, set when another full cycle may not fit
//   cdb_en/cdb_tag   : CDB broadcast (suppressed for tag 0)
//   prf_write_*      : PRF write port (suppressed for tag 0)
//   rob_complete_*   : ROB completion strobe (asserted for every entry)
//   overflow         : sticky flag, set when a pushed result had to be dropped
// ---------------------------------------------------------------------------
module complete_buffer #(
    parameter int DEPTH  = 8,
    parameter int N_IN   = 2,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5,
    parameter int XLEN   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_IN-1:0]          ex_valid,
    input  logic [N_IN*PREG_W-1:0]   ex_tag,
    input  logic [N_IN*ROB_W-1:0]    ex_rob_idx,
    input  logic [N_IN*XLEN-1:0]     ex_result,
    input  logic                     squash,
    output logic                     ex_stall,
    output logic                     cdb_en,
    output logic [PREG_W-1:0]        cdb_tag,
    output logic                     prf_write_en,
    output logic [PREG_W-1:0]        prf_write_tag,
    output logic [XLEN-1:0]          prf_write_data,
    output logic                     rob_complete_en,
    output logic [ROB_W-1:0]         rob_complete_idx,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = PREG_W + ROB_W + XLEN;

    // FIFO storage: {tag, rob_idx, data}
    logic [EW-1:0]     mem [DEPTH];
    logic [PW-1:0]     head_reg;
    logic [PW-1:0]     tail_reg;
    logic [CW-1:0]     count_reg;
    logic              overflow_reg;

    // Per-lane views of the flattened input buses
    logic [PREG_W-1:0] lane_tag  [N_IN];
    logic [ROB_W-1:0]  lane_rob  [N_IN];
    logic [XLEN-1:0]   lane_data [N_IN];

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
        assign lane_tag[gi]  = ex_tag[gi*PREG_W +: PREG_W];
        assign lane_rob[gi]  = ex_rob_idx[gi*ROB_W +: ROB_W];
        assign lane_data[gi] = ex_result[gi*XLEN +: XLEN];
    end

    // -----------------------------------------------------------------------
    // Bypass selection: the lowest valid lane when the FIFO is empty
    // -----------------------------------------------------------------------
    logic [N_IN-1:0] byp_onehot;
    logic            byp_valid;

`ifdef COMPLETE_BYPASS_EN
    always_comb begin
        logic found;
        found      = 1'b0;
        byp_onehot = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (ex_valid[i] && !found) begin
                found         = 1'b1;
                byp_onehot[i] = 1'b1;
            end
        end
        // Gated by reset so every output is quiet while reset is held
        byp_valid = found && (count_reg == '0) && !squash && reset;
        if (!byp_valid) begin
            byp_onehot = '0;
        end
    end
`else
    assign byp_onehot = '0;
    assign byp_valid  = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Push / pop bookkeeping
    // -----------------------------------------------------------------------
    logic              pop;
    logic [N_IN-1:0]   accept;
    logic [PW-1:0]     wr_idx [N_IN];
    logic [CW-1:0]     push_cnt;
    logic              drop;

    always_comb begin
        int rank;
        int free_slots;
        pop        = (count_reg != '0);
        // A pop this cycle frees its slot for a same-cycle push
        free_slots = DEPTH - int'(count_reg) + (pop ? 1 : 0);
        rank       = 0;
        accept     = '0;
        push_cnt   = '0;
        drop       = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            wr_idx[i] = '0;
        end
        // Compaction: each surviving valid lane takes the next slot after
        // tail; lanes beyond the free space (highest index first) are lost.
        for (int i = 0; i < N_IN; i++) begin
            if (ex_valid[i] && !byp_onehot[i]) begin
                if (rank < free_slots) begin
                    accept[i] = 1'b1;
                    wr_idx[i] = tail_reg + PW'(rank);
                    push_cnt  = push_cnt + CW'(1);
                end else begin
                    drop = 1'b1;
                end
                rank = rank + 1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (squash) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            head_reg  <= head_reg + PW'(pop);
            tail_reg  <= tail_reg + push_cnt[PW-1:0];
            count_reg <= count_reg + push_cnt - CW'(pop);
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage has no reset; only entries between head and tail are meaningful
    always_ff @(posedge clock) begin
        if (!squash) begin
            for (int i = 0; i < N_IN; i++) begin
                if (accept[i]) begin
                    mem[wr_idx[i]] <= {lane_tag[i], lane_rob[i], lane_data[i]};
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Retirement outputs, combinational from the head entry (or bypass lane)
    // -----------------------------------------------------------------------
    logic [EW-1:0]     head_entry;
    logic              sel_valid;
    logic [PREG_W-1:0] sel_tag;
    logic [ROB_W-1:0]  sel_rob;
    logic [XLEN-1:0]   sel_data;
    logic              bcast;

    assign head_entry = mem[head_reg];

    always_comb begin
        sel_valid = (count_reg != '0);
        sel_tag   = head_entry[EW-1 -: PREG_W];
        sel_rob   = head_entry[XLEN +: ROB_W];
        sel_data  = head_entry[XLEN-1:0];
        if (byp_valid) begin
            sel_valid = 1'b1;
            for (int i = 0; i < N_IN; i++) begin
                if (byp_onehot[i]) begin
                    sel_tag  = lane_tag[i];
                    sel_rob  = lane_rob[i];
                    sel_data = lane_data[i];
                end
            end
        end
    end

    // Tag 0 is the hardwired-zero register: complete it in the ROB but never
    // broadcast it or write the PRF.
    assign bcast            = sel_valid && (sel_tag != '0);
    assign cdb_en           = bcast;
    assign cdb_tag          = bcast ? sel_tag : '0;
    assign prf_write_en     = bcast;
    assign prf_write_tag    = bcast ? sel_tag : '0;
    assign prf_write_data   = bcast ? sel_data : '0;
    assign rob_complete_en  = sel_valid;
    assign rob_complete_idx = sel_valid ? sel_rob : '0;

    // Stall depends only on registered occupancy, never on ex_valid
    assign ex_stall = (count_reg > CW'(DEPTH - N_IN));
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_complete_buffer.sv
// ---------------------------------------------------------------------------
// tb_complete_buffer
//
// Self-checking bench for complete_buffer (DEPTH=8, N_IN=2). Single-cycle
// behaviour is driven from a table of directed vectors. Back-pressure,
// overflow, squash, reset and (when COMPLETE_BYPASS_EN is defined) bypass are
// exercised by hand-written sequences. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_complete_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ex_valid;
    logic [11:0] ex_tag;
    logic [9:0]  ex_rob_idx;
    logic [63:0] ex_result;
    logic        squash;
    logic        ex_stall;
    logic        cdb_en;
    logic [5:0]  cdb_tag;
    logic        prf_write_en;
    logic [5:0]  prf_write_tag;
    logic [31:0] prf_write_data;
    logic        rob_complete_en;
    logic [4:0]  rob_complete_idx;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    complete_buffer #(
        .DEPTH(8), .N_IN(2), .PREG_W(6), .ROB_W(5), .XLEN(32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ex_valid        (ex_valid),
        .ex_tag          (ex_tag),
        .ex_rob_idx      (ex_rob_idx),
        .ex_result       (ex_result),
        .squash          (squash),
        .ex_stall        (ex_stall),
        .cdb_en          (cdb_en),
        .cdb_tag         (cdb_tag),
        .prf_write_en    (prf_write_en),
        .prf_write_tag   (prf_write_tag),
        .prf_write_data  (prf_write_data),
        .rob_complete_en (rob_complete_en),
        .rob_complete_idx(rob_complete_idx),
        .overflow        (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  v;
        logic [5:0]  t0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic [5:0]  t1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        e_cdb;
        logic [5:0]  e_tag;
        logic [31:0] e_data;
        logic        e_rob;
        logic [4:0]  e_idx;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_raw(input logic [1:0] v,
                             input logic [5:0] t0, input logic [4:0] r0, input logic [31:0] d0,
                             input logic [5:0] t1, input logic [4:0] r1, input logic [31:0] d1,
                             input logic sq);
        ex_valid   = v;
        ex_tag     = {t1, t0};
        ex_rob_idx = {r1, r0};
        ex_result  = {d1, d0};
        squash     = sq;
    endtask

    // Sequence helper: rob index = tag[4:0], data = tag*100
    task automatic drive_tags(input logic [1:0] v, input int t0, input int t1, input logic sq);
        drive_raw(v, 6'(t0), 5'(t0), 32'(t0 * 100), 6'(t1), 5'(t1), 32'(t1 * 100), sq);
    endtask

    task automatic idle();
        drive_raw(2'b00, '0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    // Full output check for a head entry carrying tag t (t != 0)
    task automatic chk_head(input string name, input int t);
        chk({name, ".cdb_en"},   cdb_en, 1);
        chk({name, ".cdb_tag"},  cdb_tag, 64'(t));
        chk({name, ".prf_tag"},  prf_write_tag, 64'(t));
        chk({name, ".prf_data"}, prf_write_data, 64'(t * 100));
        chk({name, ".rob_idx"},  rob_complete_idx, 64'(t % 32));
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".cdb_en"},  cdb_en, 0);
        chk({name, ".cdb_tag"}, cdb_tag, 0);
        chk({name, ".prf_en"},  prf_write_en, 0);
        chk({name, ".rob_en"},  rob_complete_en, 0);
        chk({name, ".rob_idx"}, rob_complete_idx, 0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        #1;
        $display("[TB] reset state");
        chk_quiet("reset");
        chk("reset.stall", ex_stall, 0);
        chk("reset.overflow", overflow, 0);
        chk("reset.prf_data", prf_write_data, 0);
        #2 reset = 1'b1;
        tick();

`ifndef COMPLETE_BYPASS_EN
        // ---------------- table-driven single-cycle vectors ----------------
        //          v      t0  r0  d0  t1  r1  d1   cdb tag data rob idx
        vecs[0] = '{2'b00,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0};
        vecs[1] = '{2'b01, 33,  4,  9,  0,  0,  0,  1, 33,  9,  1, 4};
        vecs[2] = '{2'b00,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0};
        vecs[3] = '{2'b11, 40,  1,  1, 41,  2,  2,  1, 40,  1,  1, 1};
        vecs[4] = '{2'b00,  0,  0,  0,  0,  0,  0,  1, 41,  2,  1, 2};
        vecs[5] = '{2'b00,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0};
        vecs[6] = '{2'b01,  0,  7,  5,  0,  0,  0,  0,  0,  0,  1, 7};
        vecs[7] = '{2'b00,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0};
        vecs[8] = '{2'b10,  0,  0,  0, 12,  3, 77,  1, 12, 77,  1, 3};
        vecs[9] = '{2'b00,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0};

        for (int i = 0; i < 10; i++) begin
            drive_raw(vecs[i].v, vecs[i].t0, vecs[i].r0, vecs[i].d0,
                      vecs[i].t1, vecs[i].r1, vecs[i].d1, 1'b0);
            tick();
            $display("[TB] vec %0d: valid=%b cdb_en=%0d cdb_tag=%0d rob_en=%0d rob_idx=%0d",
                     i, vecs[i].v, cdb_en, cdb_tag, rob_complete_en, rob_complete_idx);
            chk($sformatf("vec%0d.cdb_en", i),   cdb_en,           vecs[i].e_cdb);
            chk($sformatf("vec%0d.cdb_tag", i),  cdb_tag,          vecs[i].e_tag);
            chk($sformatf("vec%0d.prf_en", i),   prf_write_en,     vecs[i].e_cdb);
            chk($sformatf("vec%0d.prf_tag", i),  prf_write_tag,    vecs[i].e_tag);
            chk($sformatf("vec%0d.prf_data", i), prf_write_data,   vecs[i].e_data);
            chk($sformatf("vec%0d.rob_en", i),   rob_complete_en,  vecs[i].e_rob);
            chk($sformatf("vec%0d.rob_idx", i),  rob_complete_idx, vecs[i].e_idx);
            chk($sformatf("vec%0d.stall", i),    ex_stall,         0);
        end

        // ---------------- back-pressure and overflow ----------------
        // Two pushes per cycle with one pop: count after edge k is
        // 2,3,4,5,6,7,8,8. Stall once count > 6 (k >= 6). At k=8 only one
        // slot is free (full + pop), so tag 16 is dropped and overflow sets.
        for (int k = 1; k <= 8; k++) begin
            drive_tags(2'b11, 2*k - 1, 2*k, 1'b0);
            tick();
            $display("[TB] push k=%0d: head=%0d stall=%0d overflow=%0d", k, cdb_tag, ex_stall, overflow);
            chk($sformatf("bp%0d.head", k),     cdb_tag,  64'(k));
            chk($sformatf("bp%0d.stall", k),    ex_stall, (k >= 6) ? 1 : 0);
            chk($sformatf("bp%0d.overflow", k), overflow, (k == 8) ? 1 : 0);
        end
        idle();
        // Remaining queue: tags 8..15 in order
        for (int j = 0; j < 8; j++) begin
            $display("[TB] drain %0d: head=%0d stall=%0d", j, cdb_tag, ex_stall);
            chk_head($sformatf("drain%0d", j), 8 + j);
            if (j == 0) chk("drain0.stall", ex_stall, 1);
            tick();
        end
        chk_quiet("drain_end");
        chk("drain_end.overflow", overflow, 1);
        chk("drain_end.stall", ex_stall, 0);

        // ---------------- squash ----------------
        // Four double pushes -> count 5, head tag 23
        for (int k = 0; k < 4; k++) begin
            drive_tags(2'b11, 20 + 2*k, 21 + 2*k, 1'b0);
            tick();
        end
        $display("[TB] pre-squash: head=%0d", cdb_tag);
        chk_head("presquash", 23);
        drive_tags(2'b11, 50, 51, 1'b1);
        tick();
        $display("[TB] squash: cdb_en=%0d rob_en=%0d", cdb_en, rob_complete_en);
        chk_quiet("squash");
        chk("squash.stall", ex_stall, 0);
        chk("squash.overflow", overflow, 1);
        idle();
        tick();
        chk_quiet("postsquash");
`else
        // ---------------- bypass ----------------
        drive_raw(2'b01, 35, 6, 3, 0, 0, 0, 1'b0);
        #1;
        $display("[TB] bypass single: cdb_en=%0d cdb_tag=%0d", cdb_en, cdb_tag);
        chk("byp.cdb_en", cdb_en, 1);
        chk("byp.cdb_tag", cdb_tag, 35);
        chk("byp.prf_data", prf_write_data, 3);
        chk("byp.rob_idx", rob_complete_idx, 6);
        tick();
        idle();
        #1;
        chk_quiet("byp.after");
        // Lane 0 bypasses, lane 1 queues behind it
        drive_tags(2'b11, 36, 37, 1'b0);
        #1;
        $display("[TB] bypass dual: cdb_tag=%0d", cdb_tag);
        chk_head("byp2.now", 36);
        tick();
        idle();
        #1;
        chk_head("byp2.next", 37);
        tick();
        chk_quiet("byp2.end");
`endif

        // ---------------- asynchronous reset mid-operation ----------------
        drive_tags(2'b11, 30, 31, 1'b0);
        tick();
        drive_tags(2'b11, 32, 33, 1'b0);
        tick();
        idle();
        chk("prereset.cdb_en", cdb_en, 1);
        #2 reset = 1'b0;
        #1;
        $display("[TB] async reset: cdb_en=%0d rob_en=%0d overflow=%0d", cdb_en, rob_complete_en, overflow);
        chk_quiet("asyncrst");
        chk("asyncrst.overflow", overflow, 0);
        chk("asyncrst.stall", ex_stall, 0);
        tick();
        #2 reset = 1'b1;
        tick();
        chk_quiet("postrst");
        chk("postrst.stall", ex_stall, 0);
        chk("postrst.overflow", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
